// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Holds the FSM encoding, grant identifiers and the arbitration decision.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2
  } arb_state_e;

  localparam logic GrantI = 1'b0;
  localparam logic GrantD = 1'b1;

  // D wins ties unless fetch has been starved for the maximum number of rounds.
  function automatic logic arb_pick(logic i_elig, logic d_elig, logic starved);
    logic grant;
    grant = GrantD;
    if (i_elig && !d_elig) begin
      grant = GrantI;
    end else if (i_elig && d_elig && starved) begin
      grant = GrantI;
    end
    return grant;
  endfunction

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Loadable down-counter that paces the memory wait states of one access.
// Loads Latency-1 at grant, counts down while busy, flags the final cycle.
module mem_arb_wait_cnt #(
  parameter int unsigned Latency = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned Width = (Latency > 1) ? $clog2(Latency) : 1;
  localparam logic [Width-1:0] LoadVal = Width'(Latency - 1);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch and data access.
// Data has priority; a starvation counter guarantees fetch progress.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveLim = StarveW'(STARVE_MAX);

  arb_state_e         state_q;
  logic               i_ack_q, d_ack_q;
  logic [31:0]        i_rdata_q, d_rdata_q;
  logic [31:0]        addr_q, wdata_q;
  logic               we_q;
  logic [StarveW-1:0] starve_q;

  logic i_elig, d_elig, grant, start, wait_zero;

  // A port is masked in its own ack cycle so a still-held request is not reissued.
  assign i_elig = i_req & ~i_ack_q;
  assign d_elig = d_req & ~d_ack_q;
  assign grant  = arb_pick(i_elig, d_elig, starve_q == StarveLim);
  assign start  = (state_q == StIdle) & (i_elig | d_elig);

  mem_arb_wait_cnt #(
    .Latency (LATENCY)
  ) u_wait_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (start),
    .dec_i  (state_q != StIdle),
    .zero_o (wait_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      starve_q  <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (grant == GrantI) begin
              state_q  <= StBusyI;
              addr_q   <= i_addr;
              starve_q <= '0;
            end else begin
              state_q <= StBusyD;
              addr_q  <= d_addr;
              we_q    <= d_we;
              wdata_q <= d_wdata;
              if (i_elig && (starve_q != StarveLim)) begin
                starve_q <= starve_q + 1'b1;
              end
            end
          end
        end
        StBusyI: begin
          if (wait_zero) begin
            state_q   <= StIdle;
            i_ack_q   <= 1'b1;
            i_rdata_q <= mem_dout;
          end
        end
        StBusyD: begin
          if (wait_zero) begin
            state_q <= StIdle;
            d_ack_q <= 1'b1;
            if (!we_q) begin
              d_rdata_q <= mem_dout;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory side decodes only state and latches; write fires once, in the last busy cycle.
  assign busy      = (state_q != StIdle);
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_din   = (state_q == StBusyD) ? wdata_q : '0;
  assign mem_read  = (state_q == StBusyI) | ((state_q == StBusyD) & ~we_q);
  assign mem_write = (state_q == StBusyD) & we_q & wait_zero;

  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule
